// File: rtl/axa_pkg.sv
// Shared sizing and FSM encoding for the AXA undo stack.
package axa_pkg;

  localparam int STACK_DEPTH = 16;
  localparam int WORD_W      = 16;
  localparam int UPTR_W      = $clog2(STACK_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    REWIND = 1'b1
  } rewind_state_t;

endpackage

// File: rtl/undo_ram.sv
// Undo stack storage: one synchronous write port, two asynchronous read ports
// (top-of-stack and operand peek). Contents are never reset.
module undo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    top_addr,
  output logic [WIDTH-1:0] top_data,
  input  logic [PW-1:0]    peek_addr,
  output logic [WIDTH-1:0] peek_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign top_data  = mem[top_addr];
  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/undo_stack_ctrl.sv
// Circular LIFO controller for the AXA undo stack: push/pop arbitration,
// occupancy and overflow tracking, commit, and the sequenced rewind FSM.
module undo_stack_ctrl
  import axa_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int WIDTH = WORD_W,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ack,
  input  logic             pop_req,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             pop_err,
  input  logic [PW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
  input  logic             commit,
  input  logic             rewind_req,
  input  logic [PW:0]      rewind_n,
  output logic             busy,
  output logic [PW-1:0]    sp,
  output logic [PW:0]      count,
  output logic             lost
);

  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  rewind_state_t    state_reg, state_next;
  logic [PW-1:0]    sp_reg, sp_next;
  logic [PW:0]      count_reg, count_next;
  logic [PW:0]      remaining_reg, remaining_next;
  logic             lost_reg, lost_next;
  logic [WIDTH-1:0] pop_data_reg, pop_data_next;
  logic             push_ack_reg, push_ack_next;
  logic             pop_valid_reg, pop_valid_next;
  logic             pop_err_reg, pop_err_next;

  logic             we;
  logic [PW-1:0]    waddr;
  logic [PW-1:0]    top_addr;
  logic [PW-1:0]    peek_addr;
  logic [WIDTH-1:0] top_data;

  assign top_addr  = sp_reg - PTR_ONE;
  assign peek_addr = sp_reg - peek_idx - PTR_ONE;

  undo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PW(PW)) u_ram (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (push_data),
    .top_addr  (top_addr),
    .top_data  (top_data),
    .peek_addr (peek_addr),
    .peek_data (peek_data)
  );

  always_comb begin
    state_next     = state_reg;
    sp_next        = sp_reg;
    count_next     = count_reg;
    remaining_next = remaining_reg;
    lost_next      = lost_reg;
    pop_data_next  = pop_data_reg;
    push_ack_next  = 1'b0;
    pop_valid_next = 1'b0;
    pop_err_next   = 1'b0;
    we             = 1'b0;
    waddr          = sp_reg;

    if (commit) begin
      // Commit wins over everything, including an in-flight rewind.
      count_next = '0;
      lost_next  = 1'b0;
      state_next = IDLE;
    end else if (state_reg == REWIND) begin
      if (count_reg == '0) begin
        pop_err_next = 1'b1;
        state_next   = IDLE;
      end else begin
        pop_data_next  = top_data;
        pop_valid_next = 1'b1;
        sp_next        = top_addr;
        count_next     = count_reg - CNT_ONE;
        remaining_next = remaining_reg - CNT_ONE;
        if (remaining_reg == CNT_ONE) state_next = IDLE;
      end
    end else if (rewind_req && rewind_n != '0) begin
      state_next     = REWIND;
      remaining_next = rewind_n;
    end else begin
      unique case ({push_req, pop_req})
        2'b11: begin
          push_ack_next = 1'b1;
          we            = 1'b1;
          if (count_reg != '0) begin
            // Swap in place: old top goes out, new value takes its slot.
            pop_data_next  = top_data;
            pop_valid_next = 1'b1;
            waddr          = top_addr;
          end else begin
            pop_err_next = 1'b1;
            sp_next      = sp_reg + PTR_ONE;
            count_next   = CNT_ONE;
          end
        end
        2'b10: begin
          push_ack_next = 1'b1;
          we            = 1'b1;
          sp_next       = sp_reg + PTR_ONE;
          if (count_reg == CNT_FULL) lost_next = 1'b1;
          else                       count_next = count_reg + CNT_ONE;
        end
        2'b01: begin
          if (count_reg != '0) begin
            pop_data_next  = top_data;
            pop_valid_next = 1'b1;
            sp_next        = top_addr;
            count_next     = count_reg - CNT_ONE;
          end else begin
            pop_err_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      sp_reg        <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
      lost_reg      <= 1'b0;
      pop_data_reg  <= '0;
      push_ack_reg  <= 1'b0;
      pop_valid_reg <= 1'b0;
      pop_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sp_reg        <= sp_next;
      count_reg     <= count_next;
      remaining_reg <= remaining_next;
      lost_reg      <= lost_next;
      pop_data_reg  <= pop_data_next;
      push_ack_reg  <= push_ack_next;
      pop_valid_reg <= pop_valid_next;
      pop_err_reg   <= pop_err_next;
    end
  end

  assign push_ack  = push_ack_reg;
  assign pop_data  = pop_data_reg;
  assign pop_valid = pop_valid_reg;
  assign pop_err   = pop_err_reg;
  assign busy      = (state_reg == REWIND);
  assign sp        = sp_reg;
  assign count     = count_reg;
  assign lost      = lost_reg;

endmodule

// File: tb/tb_undo_stack_ctrl.sv
// Directed and randomized checks of undo_stack_ctrl against a queue-based LIFO model.
module tb_undo_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push_req = 1'b0;
  logic [15:0] push_data = '0;
  logic        push_ack;
  logic        pop_req = 1'b0;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        pop_err;
  logic [3:0]  peek_idx = '0;
  logic [15:0] peek_data;
  logic        commit = 1'b0;
  logic        rewind_req = 1'b0;
  logic [4:0]  rewind_n = '0;
  logic        busy;
  logic [3:0]  sp;
  logic [4:0]  count;
  logic        lost;

  undo_stack_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .push_req   (push_req),
    .push_data  (push_data),
    .push_ack   (push_ack),
    .pop_req    (pop_req),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .pop_err    (pop_err),
    .peek_idx   (peek_idx),
    .peek_data  (peek_data),
    .commit     (commit),
    .rewind_req (rewind_req),
    .rewind_n   (rewind_n),
    .busy       (busy),
    .sp         (sp),
    .count      (count),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the queue holds valid entries oldest-first.
  logic [15:0] q[$];
  int          m_sp = 0;
  logic        m_lost = 1'b0;
  logic        m_busy = 1'b0;
  int          m_rem = 0;
  logic [15:0] e_pd = '0;
  logic        e_ack, e_valid, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic pu, input logic po, input logic [15:0] d,
                       input logic cm, input logic rw, input logic [4:0] rn);
    e_ack = 1'b0; e_valid = 1'b0; e_err = 1'b0;
    if (cm) begin
      q.delete();
      m_lost = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (q.size() == 0) begin
        e_err = 1'b1; m_busy = 1'b0;
      end else begin
        e_pd = q.pop_back(); e_valid = 1'b1;
        m_sp = (m_sp + 15) % 16;
        m_rem--;
        if (m_rem == 0) m_busy = 1'b0;
      end
    end else if (rw && rn != 0) begin
      m_busy = 1'b1; m_rem = int'(rn);
    end else if (pu && po) begin
      e_ack = 1'b1;
      if (q.size() > 0) begin
        e_pd = q[q.size()-1]; e_valid = 1'b1;
        q[q.size()-1] = d;
      end else begin
        q.push_back(d); m_sp = (m_sp + 1) % 16; e_err = 1'b1;
      end
    end else if (pu) begin
      e_ack = 1'b1;
      q.push_back(d); m_sp = (m_sp + 1) % 16;
      if (q.size() > 16) begin
        void'(q.pop_front()); m_lost = 1'b1;
      end
    end else if (po) begin
      if (q.size() > 0) begin
        e_pd = q.pop_back(); e_valid = 1'b1; m_sp = (m_sp + 15) % 16;
      end else e_err = 1'b1;
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic [15:0] d,
                      input logic cm, input logic rw, input logic [4:0] rn);
    int idx;
    push_req = pu; pop_req = po; push_data = d;
    commit = cm; rewind_req = rw; rewind_n = rn;
    model(pu, po, d, cm, rw, rn);
    @(posedge clk);
    #1;
    chk("push_ack", push_ack, e_ack);
    chk("pop_valid", pop_valid, e_valid);
    chk("pop_err", pop_err, e_err);
    chk("pop_data", pop_data, e_pd);
    chk("sp", sp, m_sp[3:0]);
    chk("count", count, q.size());
    chk("lost", lost, m_lost);
    chk("busy", busy, m_busy);
    if (q.size() > 0) begin
      idx = $urandom_range(0, q.size() - 1);
      peek_idx = idx[3:0];
      #1;
      chk("peek_data", peek_data, q[q.size()-1-idx]);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic push(input logic [15:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic pop();
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic do_commit();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 5'd0);
  endtask

  initial begin
    logic       pu, po, cm, rw;
    logic [4:0] rn;
    int         r;

    // Reset state while reset is held
    #12;
    chk("rst_sp", sp, 0);
    chk("rst_count", count, 0);
    chk("rst_lost", lost, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_pulses", {push_ack, pop_valid, pop_err}, 0);
    @(negedge clk) reset = 1'b0;

    // Push 1,2,3, peek, pop
    push(16'd1); push(16'd2); push(16'd3);
    chk("p3_count", count, 3);
    chk("p3_sp", sp, 3);
    peek_idx = 4'd0; #1 chk("peek0", peek_data, 16'd3);
    peek_idx = 4'd2; #1 chk("peek2", peek_data, 16'd1);
    pop();
    chk("pop3_data", pop_data, 16'd3);
    chk("pop3_count", count, 2);
    do_commit();

    // Overflow: 17 pushes, 16 pops, then underflow
    for (int i = 0; i <= 16; i++) push(16'(i));
    chk("ovf_count", count, 16);
    chk("ovf_lost", lost, 1);
    pop();
    chk("ovf_first_pop", pop_data, 16'd16);
    for (int i = 0; i < 15; i++) pop();
    chk("ovf_last_pop", pop_data, 16'd1);
    pop();
    chk("underflow_err", pop_err, 1);
    chk("underflow_count", count, 0);
    do_commit();
    chk("commit_lost", lost, 0);

    // Same-cycle push and pop
    push(16'd4); push(16'd7);
    step(1'b1, 1'b1, 16'd9, 1'b0, 1'b0, 5'd0);
    chk("swap_pop_data", pop_data, 16'd7);
    peek_idx = 4'd0; #1 chk("swap_peek", peek_data, 16'd9);
    chk("swap_count", count, 2);
    do_commit();

    // Same-cycle push and pop on empty
    step(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 5'd0);
    chk("empty_swap_err", pop_err, 1);
    chk("empty_swap_count", count, 1);
    do_commit();

    // Rewind 3 of 5, with push attempts while busy
    for (int i = 1; i <= 5; i++) push(16'(16'h100 + i));
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 5'd3);
    chk("rw_busy0", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, 5'd0);
      chk("rw_no_ack", push_ack, 0);
      chk("rw_data", pop_data, 16'(16'h105 - i));
    end
    chk("rw_done_busy", busy, 0);
    chk("rw_done_count", count, 2);

    // Rewind past empty
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 5'd4);
    idle(); idle(); idle();
    chk("rw_empty_err", pop_err, 1);
    chk("rw_empty_busy", busy, 0);
    do_commit();
    chk("rw_commit_count", count, 0);

    // Asynchronous reset in the middle of a rewind
    for (int i = 0; i < 5; i++) push(16'($urandom));
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 5'd4);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("arst_sp", sp, 0);
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    q.delete(); m_sp = 0; m_lost = 1'b0; m_busy = 1'b0; e_pd = '0;
    @(negedge clk) reset = 1'b0;
    idle();

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      r  = $urandom_range(0, 99);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      cm = 1'b0; rw = 1'b0;
      rn = 5'($urandom_range(0, 16));
      if (r < 3) cm = 1'b1;
      else if (r < 10) begin
        rw = 1'b1;
        if (!m_busy) begin pu = 1'b0; po = 1'b0; end
      end
      step(pu, po, 16'($urandom), cm, rw, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
